uart_tx_fifo: RTL and testbench

- Parametrised UART transmitter with a small input FIFO.
- Generalises the fixed 10-bit rotating tx shifter: configurable bit period, data width, parity mode and stop bits, plus a valid/ready byte interface.
- Sits between message/byte producers and the SER_TX pin, running in the divided system clock domain.
- Sends frames back-to-back with no idle gap while the FIFO holds data.

---
 rtl/uart_tx_fifo.sv | 235 +++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small valid/ready FIFO.
// Frame = start bit, DATA_BITS data bits (LSB first), optional parity bit,
// STOP_BITS stop bits. Each bit lasts CLOCKS_PER_BIT clock cycles. While the
// FIFO holds data, frames are sent back-to-back with no idle cycle between.
//
// Handshake: a word is taken into the FIFO at a rising edge where
// in_valid && in_ready. in_ready is simply !full; a pop in the same cycle
// does not make room (no push-through). A producer that sees in_ready low
// must keep in_valid and in_data steady until the transfer happens.
module uart_tx_fifo #(
  parameter int CLOCKS_PER_BIT = 8,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          ser_tx,
  output logic                          busy,
  output logic [2:0]                    state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  // Bit timer width; a one-cycle bit period still needs a 1-bit counter.
  localparam int TW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] TIMER_LOAD = TW'(CLOCKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_BITS - 1);
  // Index of the final stop bit: 0 for one stop bit, 1 for two.
  localparam logic          STOP_LAST  = (STOP_BITS == 2);
  // Odd parity inverts the plain XOR of the data bits.
  localparam logic          PAR_ODD    = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // ---------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] head;

  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign head     = mem[rd_ptr_q];

  // Storage array: written at the tail on an accepted push, no reset needed.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap at the power-of-two depth.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign fifo_count = count_q;

  // ---------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------
  state_t               state_q,    state_d;
  logic [TW-1:0]        timer_q,    timer_d;
  logic [BW-1:0]        bit_idx_q,  bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q,    shift_d;
  logic                 parity_q,   parity_d;
  logic                 ser_tx_q,   ser_tx_d;
  logic                 bit_done;

  assign bit_done = (timer_q == '0);

  // State and datapath registers; reset drops any frame and idles the line high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      ser_tx_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      ser_tx_q   <= ser_tx_d;
    end
  end

  // Next-state logic; ser_tx_d is the line level for the cycle after the edge,
  // so the pin comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    ser_tx_d   = ser_tx_q;
    pop        = 1'b0;

    case (state_q)
      S_IDLE: begin
        ser_tx_d = 1'b1;
        if (!empty) begin
          pop = 1'b1;
        end
      end

      S_START: begin
        if (bit_done) begin
          state_d   = S_DATA;
          timer_d   = TIMER_LOAD;
          bit_idx_d = '0;
          ser_tx_d  = shift_q[0];
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      S_DATA: begin
        if (bit_done) begin
          timer_d = TIMER_LOAD;
          if (bit_idx_q == LAST_BIT) begin
            if (PARITY != 0) begin
              state_d  = S_PARITY;
              ser_tx_d = parity_q;
            end else begin
              state_d    = S_STOP;
              stop_idx_d = 1'b0;
              ser_tx_d   = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
            shift_d   = shift_q >> 1;
            ser_tx_d  = shift_q[1];
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      S_PARITY: begin
        if (bit_done) begin
          state_d    = S_STOP;
          timer_d    = TIMER_LOAD;
          stop_idx_d = 1'b0;
          ser_tx_d   = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      S_STOP: begin
        if (bit_done) begin
          if (stop_idx_q == STOP_LAST) begin
            if (!empty) begin
              pop = 1'b1;
            end else begin
              state_d  = S_IDLE;
              ser_tx_d = 1'b1;
            end
          end else begin
            stop_idx_d = 1'b1;
            timer_d    = TIMER_LOAD;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      default: begin
        state_d  = S_IDLE;
        ser_tx_d = 1'b1;
      end
    endcase

    // A pop always starts a new frame: latch the head word and its parity.
    if (pop) begin
      state_d  = S_START;
      timer_d  = TIMER_LOAD;
      shift_d  = head;
      parity_d = (^head) ^ PAR_ODD;
      ser_tx_d = 1'b0;
    end
  end

  assign ser_tx    = ser_tx_q;
  assign busy      = (state_q != S_IDLE) || !empty;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four instances with different frame formats.
// u0: 8N1, 8 clocks/bit   u1: 8E1, 2 clocks/bit
// u2: 8O1, 2 clocks/bit   u3: 7N2, 1 clock/bit
// Expected frames are written as bit vectors, bit 0 = start bit, with bit 12
// set when the frame must follow the previous stop bit with no idle cycle.
module tb_uart_tx_fifo;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid   [4];
  logic [8:0]  in_data    [4];
  logic        in_ready   [4];
  logic [2:0]  fifo_count [4];
  logic        ser_tx     [4];
  logic        busy       [4];
  logic [2:0]  state_dbg  [4];

  logic [12:0] exp_q [4][$];
  int          n_checks = 0;
  int          n_fail   = 0;
  longint      cycle    = 0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // ---------------- DUTs and frame monitors ----------------
  for (genvar g = 0; g < 4; g++) begin : gen_dut
    localparam int CPB = (g == 0) ? 8 : ((g == 3) ? 1 : 2);
    localparam int DB  = (g == 3) ? 7 : 8;
    localparam int PAR = (g == 1) ? 2 : ((g == 2) ? 1 : 0);
    localparam int SB  = (g == 3) ? 2 : 1;
    localparam int NB  = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;

    uart_tx_fifo #(
      .CLOCKS_PER_BIT(CPB),
      .DATA_BITS     (DB),
      .PARITY        (PAR),
      .STOP_BITS     (SB),
      .FIFO_DEPTH    (4)
    ) u_dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_data   (in_data[g][DB-1:0]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .fifo_count(fifo_count[g]),
      .ser_tx    (ser_tx[g]),
      .busy      (busy[g]),
      .state_dbg (state_dbg[g])
    );

    // Monitor: on a start bit, sample every cycle of the frame, then pop and compare.
    initial begin : monitor
      logic [11:0] obs;
      logic [12:0] e;
      logic        stable;
      logic        aborted;
      int          gap;
      gap = 0;
      forever begin
        @(negedge clock);
        if (reset_n === 1'b1 && ser_tx[g] === 1'b0) begin
          obs = '0;
          stable = 1'b1;
          aborted = 1'b0;
          for (int i = 0; i < NB; i++) begin
            for (int c = 0; c < CPB; c++) begin
              if (i != 0 || c != 0) @(negedge clock);
              if (reset_n !== 1'b1) aborted = 1'b1;
              if (c == 0) obs[i] = ser_tx[g];
              else if (ser_tx[g] !== obs[i]) stable = 1'b0;
            end
          end
          if (!aborted) begin
            if (exp_q[g].size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_frame_u%0d: got frame 0x%0h, required no frame (cycle %0d)",
                       g, obs, cycle);
            end else begin
              e = exp_q[g].pop_front();
              check_eq($sformatf("frame_u%0d", g), {19'd0, stable, obs}, {19'd0, 1'b1, e[11:0]});
              if (e[12]) check_eq($sformatf("gap_u%0d", g), gap, 0);
            end
          end
          gap = 0;
        end else begin
          gap++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input int g, input logic [8:0] d);
    int t;
    in_data[g]  = d;
    in_valid[g] = 1'b1;
    t = 0;
    while (in_ready[g] !== 1'b1 && t < 2000) begin
      @(negedge clock);
      t++;
    end
    if (t >= 2000) check_eq($sformatf("push_timeout_u%0d", g), 0, 1);
    @(negedge clock);
    in_valid[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int t;
    t = 0;
    while ((busy[g] !== 1'b0 || exp_q[g].size() != 0) && t < 5000) begin
      @(negedge clock);
      t++;
    end
    check_eq($sformatf("idle_reached_u%0d", g), (t < 5000), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stimulus
    int t;
    logic line_ok;
    reset_n = 1'b0;
    for (int g = 0; g < 4; g++) begin
      in_valid[g] = 1'b0;
      in_data[g]  = '0;
    end
    repeat (3) @(negedge clock);
    // {ser_tx, in_ready, busy, fifo_count, state}
    for (int g = 0; g < 4; g++)
      check_eq($sformatf("reset_state_u%0d", g),
               {ser_tx[g], in_ready[g], busy[g], fifo_count[g], state_dbg[g]}, 9'b110_000_000);
    reset_n = 1'b1;
    @(negedge clock);

    // 8N1, 0x55: start at E1, busy falls at E1+80.
    exp_q[0].push_back(13'h02AA);
    push(0, 9'h055);
    check_eq("after_e0_count", fifo_count[0], 1);
    check_eq("after_e0_line_idle", ser_tx[0], 1);
    check_eq("after_e0_busy", busy[0], 1);
    @(negedge clock);
    check_eq("start_at_e1", ser_tx[0], 0);
    check_eq("popped_at_e1", fifo_count[0], 0);
    repeat (79) @(negedge clock);
    check_eq("busy_at_e1_79", busy[0], 1);
    @(negedge clock);
    check_eq("busy_at_e1_80", busy[0], 0);
    wait_idle(0);

    // Odd parity 0x07 -> parity 0; even parity 0x07 -> parity 1, 22-cycle frame.
    exp_q[2].push_back(13'h040E);
    push(2, 9'h007);
    wait_idle(2);
    exp_q[1].push_back(13'h060E);
    push(1, 9'h007);
    @(negedge clock);
    check_eq("even_start_at_e1", ser_tx[1], 0);
    repeat (21) @(negedge clock);
    check_eq("even_busy_at_e1_21", busy[1], 1);
    @(negedge clock);
    check_eq("even_busy_at_e1_22", busy[1], 0);
    wait_idle(1);

    // 7N2 at one clock per bit, 0x7F: 0 then nine 1s, idle at E1+10.
    exp_q[3].push_back(13'h03FE);
    push(3, 9'h07F);
    @(negedge clock);
    check_eq("7n2_start_at_e1", ser_tx[3], 0);
    repeat (9) @(negedge clock);
    check_eq("7n2_busy_at_e1_9", busy[3], 1);
    @(negedge clock);
    check_eq("7n2_idle_at_e1_10", {busy[3], ser_tx[3]}, 2'b01);
    wait_idle(3);

    // Full FIFO drops a push; later push and pop in one cycle at count 3.
    exp_q[3].push_back(13'h0322);
    exp_q[3].push_back(13'h1344);
    exp_q[3].push_back(13'h1366);
    exp_q[3].push_back(13'h1388);
    exp_q[3].push_back(13'h13AA);
    exp_q[3].push_back(13'h13CC);
    push(3, 9'h011);
    push(3, 9'h022);
    push(3, 9'h033);
    push(3, 9'h044);
    push(3, 9'h055);
    check_eq("u3_full_count", fifo_count[3], 4);
    check_eq("u3_full_not_ready", in_ready[3], 0);
    in_data[3]  = 9'h07E;
    in_valid[3] = 1'b1;
    @(negedge clock);
    in_valid[3] = 1'b0;
    check_eq("u3_drop_while_full", fifo_count[3], 4);
    t = 0;
    while (fifo_count[3] !== 3'd3 && t < 100) begin
      @(negedge clock);
      t++;
    end
    check_eq("u3_reached_count3", (t < 100), 1);
    repeat (9) @(negedge clock);
    check_eq("u3_ready_at_count3", in_ready[3], 1);
    in_data[3]  = 9'h066;
    in_valid[3] = 1'b1;
    @(negedge clock);
    in_valid[3] = 1'b0;
    check_eq("u3_push_pop_same_cycle", fifo_count[3], 3);
    wait_idle(3);

    // Hold in_valid with 0x01..0x06: fills to 4, frames back-to-back.
    exp_q[0].push_back(13'h0202);
    exp_q[0].push_back(13'h1204);
    exp_q[0].push_back(13'h1206);
    exp_q[0].push_back(13'h1208);
    exp_q[0].push_back(13'h120A);
    exp_q[0].push_back(13'h120C);
    push(0, 9'h001);
    push(0, 9'h002);
    push(0, 9'h003);
    push(0, 9'h004);
    push(0, 9'h005);
    check_eq("u0_fifo_full", fifo_count[0], 4);
    check_eq("u0_not_ready_full", in_ready[0], 0);
    push(0, 9'h006);
    wait_idle(0);

    // Reset in the middle of a data bit with two bytes queued.
    push(0, 9'h0A5);
    push(0, 9'h03C);
    push(0, 9'h081);
    repeat (17) @(negedge clock);
    check_eq("pre_reset_count", fifo_count[0], 2);
    check_eq("pre_reset_line_low", ser_tx[0], 0);
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_reset_ser_tx", ser_tx[0], 1);
    check_eq("async_reset_count", fifo_count[0], 0);
    check_eq("async_reset_ready", in_ready[0], 1);
    check_eq("async_reset_busy", busy[0], 0);
    check_eq("async_reset_state", state_dbg[0], 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    line_ok = 1'b1;
    repeat (100) begin
      @(negedge clock);
      if (ser_tx[0] !== 1'b1 || busy[0] !== 1'b0) line_ok = 1'b0;
    end
    check_eq("quiet_after_reset", line_ok, 1);

    // The transmitter resumes normally with a fresh push.
    exp_q[0].push_back(13'h0278);
    push(0, 9'h03C);
    wait_idle(0);

    for (int g = 0; g < 4; g++)
      check_eq($sformatf("leftover_frames_u%0d", g), exp_q[g].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
